// File: rtl/hl_write_arbiter.sv
// hl_write_arbiter
//   Collects byte-serial half-word writes from two requesters and commits the
//   requested halves of a split high/low load register in a single cycle, so
//   a full-word update is never observed half-written. Ownership is granted
//   round-robin; the low byte always streams first, then the high byte.
//
// Ports
//   clk          : rising-edge clock
//   clear_n      : asynchronous active-low reset
//   req[1:0]     : per-requester write request, held until done is sampled
//   req_hi[1:0]  : per-requester "write high half" flag
//   req_lo[1:0]  : per-requester "write low half" flag
//   byte_valid   : per-requester byte valid
//   byte_in0/1   : per-requester byte data (H bits)
//   gnt[1:0]     : one-hot owner, high for the whole transaction
//   byte_ready   : byte accept toward the owner while collecting bytes
//   done[1:0]    : one-cycle completion pulse to the owner
//   inh / inl    : buffered high / low half data to the register
//   loadh / loadl: half load strobes, only ever in COMMIT
//   busy         : high whenever the FSM is not idle
module hl_write_arbiter #(
  parameter int N = 16
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic [1:0]       req,
  input  logic [1:0]       req_hi,
  input  logic [1:0]       req_lo,
  input  logic [1:0]       byte_valid,
  input  logic [N/2-1:0]   byte_in0,
  input  logic [N/2-1:0]   byte_in1,
  output logic [1:0]       gnt,
  output logic [1:0]       byte_ready,
  output logic [1:0]       done,
  output logic [N/2-1:0]   inh,
  output logic [N/2-1:0]   inl,
  output logic             loadh,
  output logic             loadl,
  output logic             busy
);

  localparam int H = N / 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GET_LO = 2'd1,
    GET_HI = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t         state, state_nxt;
  logic           owner;
  logic           rr_last;   // last served requester; reset to 1 so 0 wins first
  logic           hi_en, lo_en;
  logic [H-1:0]   hi_buf, lo_buf;

  logic           win;
  logic           own_valid;
  logic [H-1:0]   own_byte;

  // On contention the requester not served last wins; otherwise the lone
  // requester wins.
  always_comb begin
    if (req == 2'b11) win = ~rr_last;
    else              win = req[1];
  end

  assign own_valid = owner ? byte_valid[1] : byte_valid[0];
  assign own_byte  = owner ? byte_in1 : byte_in0;

  // State register
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Owner, enables, round-robin pointer and byte buffers
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      owner   <= 1'b0;
      rr_last <= 1'b1;
      hi_en   <= 1'b0;
      lo_en   <= 1'b0;
      hi_buf  <= '0;
      lo_buf  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            owner <= win;
            hi_en <= req_hi[win];
            lo_en <= req_lo[win];
          end
        end
        GET_LO: if (own_valid) lo_buf <= own_byte;
        GET_HI: if (own_valid) hi_buf <= own_byte;
        COMMIT: rr_last <= owner;
        default: ;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (|req) begin
          if (req_lo[win])      state_nxt = GET_LO;
          else if (req_hi[win]) state_nxt = GET_HI;
          else                  state_nxt = COMMIT;
        end
      end
      GET_LO: if (own_valid) state_nxt = hi_en ? GET_HI : COMMIT;
      GET_HI: if (own_valid) state_nxt = COMMIT;
      COMMIT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore outputs decoded from registered state, owner and buffers
  always_comb begin
    gnt        = 2'b00;
    byte_ready = 2'b00;
    done       = 2'b00;
    loadh      = 1'b0;
    loadl      = 1'b0;
    busy       = (state != IDLE);
    case (state)
      GET_LO, GET_HI: begin
        gnt        = {owner, ~owner};
        byte_ready = {owner, ~owner};
      end
      COMMIT: begin
        gnt   = {owner, ~owner};
        done  = {owner, ~owner};
        loadh = hi_en;
        loadl = lo_en;
      end
      default: ;
    endcase
  end

  // Buffers drive the register continuously; strobes decide what lands.
  assign inh = hi_buf;
  assign inl = lo_buf;

endmodule

// File: tb/tb_hl_write_arbiter.sv
module tb_hl_write_arbiter;

  logic       clk = 1'b0;
  logic       clear_n = 1'b0;
  logic [1:0] req = 2'b00;
  logic [1:0] req_hi = 2'b00;
  logic [1:0] req_lo = 2'b00;
  logic [1:0] byte_valid = 2'b00;
  logic [7:0] byte_in0 = 8'h00;
  logic [7:0] byte_in1 = 8'h00;
  logic [1:0] gnt, byte_ready, done;
  logic [7:0] inh, inl;
  logic       loadh, loadl, busy;

  logic [15:0] regq = 16'h0000;   // the split high/low load register
  int errors = 0;
  int checks = 0;

  hl_write_arbiter #(.N(16)) dut (
    .clk(clk), .clear_n(clear_n), .req(req), .req_hi(req_hi), .req_lo(req_lo),
    .byte_valid(byte_valid), .byte_in0(byte_in0), .byte_in1(byte_in1),
    .gnt(gnt), .byte_ready(byte_ready), .done(done), .inh(inh), .inl(inl),
    .loadh(loadh), .loadl(loadl), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (loadh) regq[15:8] <= inh;
    if (loadl) regq[7:0]  <= inl;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, ".gnt"},   16'(gnt), 16'h0);
    chk({tag, ".rdy"},   16'(byte_ready), 16'h0);
    chk({tag, ".done"},  16'(done), 16'h0);
    chk({tag, ".loadh"}, 16'(loadh), 16'h0);
    chk({tag, ".loadl"}, 16'(loadl), 16'h0);
    chk({tag, ".busy"},  16'(busy), 16'h0);
  endtask

  logic [1:0] exp_own [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

  initial begin
    // Reset state
    tick(); tick();
    chk_idle_zero("rst");
    chk("rst.inh", 16'(inh), 16'h0);
    chk("rst.inl", 16'(inl), 16'h0);
    clear_n = 1'b1;

    // Requester 0 writes both halves: 0x34 then 0x12
    req = 2'b01; req_hi = 2'b01; req_lo = 2'b01; byte_valid = 2'b01; byte_in0 = 8'h34;
    tick();  // C1 GET_LO
    chk("t1.c1.gnt", 16'(gnt), 16'h1);
    chk("t1.c1.rdy", 16'(byte_ready), 16'h1);
    chk("t1.c1.busy", 16'(busy), 16'h1);
    chk("t1.c1.loadl", 16'(loadl), 16'h0);
    tick();  // C2 GET_HI
    chk("t1.c2.inl", 16'(inl), 16'h34);
    chk("t1.c2.loadh", 16'(loadh), 16'h0);
    byte_in0 = 8'h12;
    tick();  // C3 COMMIT
    chk("t1.c3.loadh", 16'(loadh), 16'h1);
    chk("t1.c3.loadl", 16'(loadl), 16'h1);
    chk("t1.c3.inh", 16'(inh), 16'h12);
    chk("t1.c3.inl", 16'(inl), 16'h34);
    chk("t1.c3.done", 16'(done), 16'h1);
    req = 2'b00; byte_valid = 2'b00;
    tick();  // C4 IDLE
    chk("t1.c4.reg", regq, 16'h1234);
    chk_idle_zero("t1.c4");

    // Requester 1 writes high half only: 0xAB
    req = 2'b10; req_hi = 2'b10; req_lo = 2'b00; byte_valid = 2'b10; byte_in1 = 8'hAB;
    tick();  // GET_HI directly
    chk("t2.gethi.gnt", 16'(gnt), 16'h2);
    chk("t2.gethi.rdy", 16'(byte_ready), 16'h2);
    tick();  // COMMIT
    chk("t2.commit.loadh", 16'(loadh), 16'h1);
    chk("t2.commit.loadl", 16'(loadl), 16'h0);
    chk("t2.commit.done", 16'(done), 16'h2);
    chk("t2.commit.inh", 16'(inh), 16'hAB);
    req = 2'b00; byte_valid = 2'b00;
    tick();
    chk("t2.reg", regq, 16'hAB34);

    // Contention after reset: alternating 0,1,0,1 with null requests
    clear_n = 1'b0; #1; clear_n = 1'b1;
    req = 2'b11; req_hi = 2'b00; req_lo = 2'b00;
    for (int k = 0; k < 4; k++) begin
      tick();  // COMMIT
      chk($sformatf("t3.%0d.gnt", k), 16'(gnt), 16'(exp_own[k]));
      chk($sformatf("t3.%0d.done", k), 16'(done), 16'(exp_own[k]));
      chk($sformatf("t3.%0d.load", k), 16'({loadh, loadl}), 16'h0);
      req = req & ~exp_own[k];
      tick();  // IDLE
      chk($sformatf("t3.%0d.idle_done", k), 16'(done), 16'h0);
      req = 2'b11;
    end
    req = 2'b00;
    tick();
    chk("t3.reg", regq, 16'hAB34);

    // Low-only write from requester 0 stalled 4 cycles; requester 1 noise
    req = 2'b01; req_hi = 2'b00; req_lo = 2'b01; byte_valid = 2'b10;
    byte_in0 = 8'h77; byte_in1 = 8'hEE;
    tick();  // C1 GET_LO
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t4.stall%0d.rdy", k), 16'(byte_ready), 16'h1);
      chk($sformatf("t4.stall%0d.done", k), 16'(done), 16'h0);
      byte_valid[1] = ~byte_valid[1];
      tick();
    end
    chk("t4.c5.rdy", 16'(byte_ready), 16'h1);
    chk("t4.c5.inl", 16'(inl), 16'h00);
    byte_valid = 2'b01;
    tick();  // C6 COMMIT
    chk("t4.c6.loadl", 16'(loadl), 16'h1);
    chk("t4.c6.loadh", 16'(loadh), 16'h0);
    chk("t4.c6.inl", 16'(inl), 16'h77);
    chk("t4.c6.done", 16'(done), 16'h1);
    req = 2'b00; byte_valid = 2'b00;
    tick();
    chk("t4.reg", regq, 16'hAB77);

    // Reset during GET_HI of a two-byte write
    req = 2'b01; req_hi = 2'b01; req_lo = 2'b01; byte_valid = 2'b01; byte_in0 = 8'h55;
    tick();  // GET_LO
    tick();  // GET_HI
    chk("t5.gethi.inl", 16'(inl), 16'h55);
    chk("t5.gethi.busy", 16'(busy), 16'h1);
    clear_n = 1'b0;
    #1;
    chk_idle_zero("t5.inrst");
    chk("t5.inrst.inl", 16'(inl), 16'h0);
    req = 2'b00; byte_valid = 2'b00;
    #1;
    clear_n = 1'b1;
    tick();
    chk_idle_zero("t5.after");
    chk("t5.reg", regq, 16'hAB77);

    // Null request from requester 1
    req = 2'b10; req_hi = 2'b00; req_lo = 2'b00;
    tick();  // COMMIT
    chk("t6.done", 16'(done), 16'h2);
    chk("t6.gnt", 16'(gnt), 16'h2);
    chk("t6.load", 16'({loadh, loadl}), 16'h0);
    req = 2'b00;
    tick();
    chk("t6.reg", regq, 16'hAB77);
    chk_idle_zero("t6.idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
